rot_tlul_host: RTL and testbench

Register-access initiator that drives a TL-UL device port (32-bit data, 4-bit mask) of the root-of-trust subsystem from a simple valid/ready command interface. It issues requests on the A channel and collects and checks responses on the D channel. It is the host-side counterpart of the subsystem's device-side TL-UL bridge, used by on-chip sequencers and test harnesses to program hmac/kmac/keymgr/csrng/edn CSRs. Up to MaxOutstanding transactions may be in flight, tracked by source ID.

---
 rtl/rot_tlul_host.sv | 113 +++++++++++
 tb/tb_rot_tlul_host.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_tlul_host.sv
// rot_tlul_host: TL-UL register-access initiator with source-ID tracking,
// response checking, and sticky unexpected-response and timeout flags.
module rot_tlul_host #(
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [7:0]  rsp_source_o,
  output logic        a_valid_o,
  output logic [2:0]  a_opcode_o,
  output logic [2:0]  a_param_o,
  output logic [1:0]  a_size_o,
  output logic [7:0]  a_source_o,
  output logic [31:0] a_address_o,
  output logic [3:0]  a_mask_o,
  output logic [31:0] a_data_o,
  input  logic        a_ready_i,
  input  logic        d_valid_i,
  input  logic [2:0]  d_opcode_i,
  input  logic [1:0]  d_size_i,
  input  logic [7:0]  d_source_i,
  input  logic [31:0] d_data_i,
  input  logic        d_error_i,
  output logic        d_ready_o,
  output logic        busy_o,
  output logic        err_unexpected_o,
  output logic        err_timeout_o,
  input  logic        clr_err_i
);
  localparam int PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int CW = $clog2(TimeoutCycles + 1);
  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;
  logic [PW-1:0]             ptr_q, d_idx;
  logic [MaxOutstanding-1:0] busy_q, we_q;
  logic [CW-1:0]             tmo_q;
  logic                      accept, d_fire, d_hit, d_we, unused_bits;
  // busy_q is read without bypass: a retiring entry frees up one cycle later
  assign req_ready_o = (!a_valid_o || a_ready_i) && !busy_q[ptr_q];
  assign accept      = req_valid_i && req_ready_o;
  assign d_ready_o   = !rsp_valid_o || rsp_ready_i;
  assign d_fire      = d_valid_i && d_ready_o;
  assign d_idx       = d_source_i[PW-1:0];
  assign d_hit       = d_fire && (d_source_i < 8'(MaxOutstanding)) && busy_q[d_idx];
  assign d_we        = we_q[d_idx];
  assign busy_o      = |busy_q;
  assign a_param_o   = 3'd0;
  assign unused_bits = ^{d_size_i, req_addr_i[1:0], d_source_i};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q            <= '0;
      busy_q           <= '0;
      we_q             <= '0;
      tmo_q            <= '0;
      a_valid_o        <= 1'b0;
      a_opcode_o       <= 3'd0;
      a_size_o         <= 2'd0;
      a_source_o       <= 8'd0;
      a_address_o      <= 32'd0;
      a_mask_o         <= 4'd0;
      a_data_o         <= 32'd0;
      rsp_valid_o      <= 1'b0;
      rsp_rdata_o      <= 32'd0;
      rsp_err_o        <= 1'b0;
      rsp_source_o     <= 8'd0;
      err_unexpected_o <= 1'b0;
      err_timeout_o    <= 1'b0;
    end else begin
      if (accept) begin
        a_valid_o      <= 1'b1;
        a_opcode_o     <= !req_we_i ? Get : (req_be_i == 4'hf ? PutFullData : PutPartialData);
        a_size_o       <= 2'd2;
        a_source_o     <= 8'(ptr_q);
        a_address_o    <= {req_addr_i[31:2], 2'b00};
        a_mask_o       <= req_we_i ? req_be_i : 4'hf;
        a_data_o       <= req_we_i ? req_wdata_i : 32'd0;
        busy_q[ptr_q]  <= 1'b1;
        we_q[ptr_q]    <= req_we_i;
        ptr_q          <= (ptr_q == PW'(MaxOutstanding - 1)) ? '0 : ptr_q + 1'b1;
      end else if (a_ready_i) begin
        a_valid_o <= 1'b0;
      end
      if (d_hit) begin
        busy_q[d_idx] <= 1'b0;
        rsp_valid_o   <= 1'b1;
        rsp_rdata_o   <= d_we ? 32'd0 : d_data_i;
        rsp_err_o     <= d_error_i || (d_opcode_i != (d_we ? AccessAck : AccessAckData));
        rsp_source_o  <= d_source_i;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
      tmo_q <= (!busy_o || d_fire) ? '0 :
               (tmo_q == CW'(TimeoutCycles)) ? tmo_q : tmo_q + 1'b1;
      err_timeout_o    <= (busy_o && !d_fire && tmo_q == CW'(TimeoutCycles - 1)) ||
                          (err_timeout_o && !clr_err_i);
      err_unexpected_o <= (d_fire && !d_hit) || (err_unexpected_o && !clr_err_i);
    end
  end
endmodule

// File: tb/tb_rot_tlul_host.sv
// tb_rot_tlul_host: directed scenarios plus a randomized run against a
// queue-based transaction model of the TL-UL host.
module tb_rot_tlul_host;
  localparam int MO = 4;
  localparam int TC = 1024;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_we = 0, rsp_ready = 1, a_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0, d_data = 0;
  logic [3:0]  req_be = 0;
  logic        d_valid = 0, d_error = 0, clr_err = 0;
  logic [2:0]  d_opcode = 0;
  logic [1:0]  d_size = 2;
  logic [7:0]  d_source = 0;
  logic        req_ready, rsp_valid, rsp_err, a_valid, d_ready, busy, err_unexp, err_tmo;
  logic [31:0] rsp_rdata, a_address, a_data;
  logic [7:0]  rsp_source, a_source;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [3:0]  a_mask;
  int checks = 0, errors = 0;

  rot_tlul_host #(.MaxOutstanding(MO), .TimeoutCycles(TC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_source_o(rsp_source),
    .a_valid_o(a_valid), .a_opcode_o(a_opcode), .a_param_o(a_param), .a_size_o(a_size),
    .a_source_o(a_source), .a_address_o(a_address), .a_mask_o(a_mask), .a_data_o(a_data),
    .a_ready_i(a_ready),
    .d_valid_i(d_valid), .d_opcode_i(d_opcode), .d_size_i(d_size), .d_source_i(d_source),
    .d_data_i(d_data), .d_error_i(d_error), .d_ready_o(d_ready),
    .busy_o(busy), .err_unexpected_o(err_unexp), .err_timeout_o(err_tmo), .clr_err_i(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [84:0] a_obs();
    return {a_valid, a_opcode, a_mask, a_address, a_source, a_size, a_param, a_data};
  endfunction

  function automatic logic [41:0] rsp_obs();
    return {rsp_valid, rsp_err, rsp_source, rsp_rdata};
  endfunction

  task automatic do_reset();
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    rsp_ready = 1; a_ready = 1; d_valid = 0; d_opcode = 0; d_size = 2; d_source = 0;
    d_data = 0; d_error = 0; clr_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    bit ok = 0;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = req_ready;
      @(negedge clk);
    end
    req_valid = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL issue_accept: req_ready stayed %b, required 1", req_ready); end
  endtask

  task automatic dbeat(input logic [7:0] src, input logic [2:0] op, input logic [31:0] data,
                       input logic err);
    bit ok = 0;
    d_valid = 1; d_source = src; d_opcode = op; d_data = data; d_error = err;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1 ok = d_ready;
      @(negedge clk);
    end
    d_valid = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL d_accept: d_ready stayed %b, required 1", d_ready); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({a_valid, rsp_valid, busy, err_unexp, err_tmo, req_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 000001",
               {a_valid, rsp_valid, busy, err_unexp, err_tmo, req_ready});
    end
    checks++;
    if ({a_obs(), rsp_obs()} !== '0) begin
      errors++; $display("FAIL reset_regs: got %h %h exp all zero", a_obs(), rsp_obs());
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [84:0] ea;
    logic [41:0] er;
    do_reset();
    issue(0, 32'h1000_0004, 32'hffff_ffff, 4'h0);
    ea = {1'b1, 3'd4, 4'hf, 32'h1000_0004, 8'd0, 2'd2, 3'd0, 32'd0};
    checks++;
    if (a_obs() !== ea) begin errors++; $display("FAIL read_a: got %h exp %h", a_obs(), ea); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b exp 1", busy); end
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b0) begin errors++; $display("FAIL read_a_drop: got %b exp 0", a_valid); end
    dbeat(8'd0, 3'd1, 32'hdead_beef, 0);
    er = {1'b1, 1'b0, 8'd0, 32'hdead_beef};
    checks++;
    if (rsp_obs() !== er) begin errors++; $display("FAIL read_rsp: got %h exp %h", rsp_obs(), er); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_idle: got %b exp 0", busy); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_drop: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_write();
    logic [84:0] ea;
    logic [41:0] er;
    do_reset();
    issue(1, 32'h2000_0007, 32'h1234_5678, 4'b0011);
    ea = {1'b1, 3'd1, 4'h3, 32'h2000_0004, 8'd0, 2'd2, 3'd0, 32'h1234_5678};
    checks++;
    if (a_obs() !== ea) begin errors++; $display("FAIL partial_a: got %h exp %h", a_obs(), ea); end
    dbeat(8'd0, 3'd0, 32'hcafe_f00d, 0);
    er = {1'b1, 1'b0, 8'd0, 32'd0};
    checks++;
    if (rsp_obs() !== er) begin errors++; $display("FAIL partial_rsp: got %h exp %h", rsp_obs(), er); end
    issue(1, 32'h3000_0010, 32'ha5a5_5a5a, 4'hf);
    ea = {1'b1, 3'd0, 4'hf, 32'h3000_0010, 8'd1, 2'd2, 3'd0, 32'ha5a5_5a5a};
    checks++;
    if (a_obs() !== ea) begin errors++; $display("FAIL full_a: got %h exp %h", a_obs(), ea); end
    dbeat(8'd1, 3'd0, 32'h0, 0);
    er = {1'b1, 1'b0, 8'd1, 32'd0};
    checks++;
    if (rsp_obs() !== er) begin errors++; $display("FAIL full_rsp: got %h exp %h", rsp_obs(), er); end
  endtask

  task automatic test_outstanding();
    logic [84:0] ea;
    logic [41:0] er;
    do_reset();
    for (int s = 0; s < MO; s++) begin
      issue(0, 32'h100 + 32'(s * 4), 0, 0);
      ea = {1'b1, 3'd4, 4'hf, 32'h100 + 32'(s * 4), 8'(s), 2'd2, 3'd0, 32'd0};
      checks++;
      if (a_obs() !== ea) begin errors++; $display("FAIL limit_a%0d: got %h exp %h", s, a_obs(), ea); end
    end
    req_valid = 1; req_we = 0; req_addr = 32'h200;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL limit_stall: got %b exp 0", req_ready); end
    @(negedge clk);
    dbeat(8'd2, 3'd1, 32'h22, 0);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_source} !== {1'b0, 1'b1, 8'd2}) begin
      errors++; $display("FAIL limit_after_src2: got %b %b %0d exp 0 1 2", req_ready, rsp_valid, rsp_source);
    end
    @(negedge clk);
    d_valid = 1; d_source = 0; d_opcode = 1; d_data = 32'h0bad_0000; d_error = 0;
    #1;
    checks++;
    if ({req_ready, d_ready} !== 2'b01) begin
      errors++; $display("FAIL limit_no_bypass: got %b exp 01", {req_ready, d_ready});
    end
    @(negedge clk);
    d_valid = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL limit_freed: got %b exp 1", req_ready); end
    er = {1'b1, 1'b0, 8'd0, 32'h0bad_0000};
    checks++;
    if (rsp_obs() !== er) begin errors++; $display("FAIL limit_rsp0: got %h exp %h", rsp_obs(), er); end
    @(negedge clk);
    req_valid = 0;
    ea = {1'b1, 3'd4, 4'hf, 32'h200, 8'd0, 2'd2, 3'd0, 32'd0};
    checks++;
    if (a_obs() !== ea) begin errors++; $display("FAIL limit_fifth: got %h exp %h", a_obs(), ea); end
  endtask

  task automatic test_unexpected();
    do_reset();
    dbeat(8'd7, 3'd1, 32'h7777, 0);
    checks++;
    if ({rsp_valid, err_unexp, busy} !== 3'b010) begin
      errors++; $display("FAIL unexp_src7: got %b exp 010", {rsp_valid, err_unexp, busy});
    end
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    checks++;
    if (err_unexp !== 1'b0) begin errors++; $display("FAIL unexp_clear: got %b exp 0", err_unexp); end
    dbeat(8'd2, 3'd1, 32'h2222, 0);
    checks++;
    if ({rsp_valid, err_unexp} !== 2'b01) begin
      errors++; $display("FAIL unexp_idle: got %b exp 01", {rsp_valid, err_unexp});
    end
    clr_err = 1;
    @(negedge clk);
    d_valid = 1; d_source = 9; d_opcode = 1;
    @(negedge clk);
    d_valid = 0; clr_err = 0;
    checks++;
    if ({err_unexp, err_tmo} !== 2'b10) begin
      errors++; $display("FAIL unexp_set_wins: got %b exp 10", {err_unexp, err_tmo});
    end
  endtask

  task automatic test_error_resp();
    logic [41:0] er;
    do_reset();
    issue(0, 32'h40, 0, 0);
    dbeat(8'd0, 3'd0, 32'h1122_3344, 0);
    er = {1'b1, 1'b1, 8'd0, 32'h1122_3344};
    checks++;
    if (rsp_obs() !== er) begin errors++; $display("FAIL err_read_ack: got %h exp %h", rsp_obs(), er); end
    issue(1, 32'h44, 32'h55, 4'hf);
    dbeat(8'd1, 3'd0, 32'h99, 1);
    er = {1'b1, 1'b1, 8'd1, 32'd0};
    checks++;
    if (rsp_obs() !== er) begin errors++; $display("FAIL err_derror: got %h exp %h", rsp_obs(), er); end
    issue(1, 32'h48, 32'h66, 4'b1000);
    dbeat(8'd2, 3'd1, 32'h88, 0);
    er = {1'b1, 1'b1, 8'd2, 32'd0};
    checks++;
    if (rsp_obs() !== er) begin errors++; $display("FAIL err_write_data: got %h exp %h", rsp_obs(), er); end
    issue(0, 32'h4c, 0, 0);
    dbeat(8'd3, 3'd1, 32'h77, 0);
    er = {1'b1, 1'b0, 8'd3, 32'h77};
    checks++;
    if (rsp_obs() !== er) begin errors++; $display("FAIL err_good_read: got %h exp %h", rsp_obs(), er); end
  endtask

  task automatic test_timeout();
    logic [41:0] er;
    do_reset();
    issue(0, 32'h50, 0, 0);
    repeat (TC - 1) @(negedge clk);
    checks++;
    if (err_tmo !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b exp 0", err_tmo); end
    @(negedge clk);
    checks++;
    if ({err_tmo, busy} !== 2'b11) begin errors++; $display("FAIL tmo_fire: got %b exp 11", {err_tmo, busy}); end
    repeat (20) @(negedge clk);
    checks++;
    if ({err_tmo, busy} !== 2'b11) begin errors++; $display("FAIL tmo_sticky: got %b exp 11", {err_tmo, busy}); end
    rsp_ready = 0;
    issue(0, 32'h54, 0, 0);
    dbeat(8'd0, 3'd1, 32'haaaa_0000, 0);
    d_valid = 1; d_source = 1; d_opcode = 1; d_data = 32'hbbbb_0000; d_error = 0;
    repeat (3) @(negedge clk);
    #1;
    er = {1'b1, 1'b0, 8'd0, 32'haaaa_0000};
    checks++;
    if ({d_ready, rsp_obs()} !== {1'b0, er}) begin
      errors++; $display("FAIL bp_hold: got %b %h exp 0 %h", d_ready, rsp_obs(), er);
    end
    @(negedge clk);
    rsp_ready = 1;
    #1;
    checks++;
    if (d_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b exp 1", d_ready); end
    @(negedge clk);
    d_valid = 0;
    er = {1'b1, 1'b0, 8'd1, 32'hbbbb_0000};
    checks++;
    if ({busy, rsp_obs()} !== {1'b0, er}) begin
      errors++; $display("FAIL bp_second: got %b %h exp 0 %h", busy, rsp_obs(), er);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    issue(0, 32'h60, 0, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({a_valid, busy, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL midrst_clear: got %b exp 000", {a_valid, busy, rsp_valid});
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dbeat(8'd0, 3'd1, 32'h1234, 0);
    checks++;
    if ({err_unexp, rsp_valid, req_ready} !== 3'b101) begin
      errors++; $display("FAIL midrst_late_d: got %b exp 101", {err_unexp, rsp_valid, req_ready});
    end
  endtask

  task automatic test_random();
    logic [84:0] exp_a[$];
    logic [41:0] exp_rsp[$];
    logic [84:0] ea;
    logic [41:0] er;
    bit          inflight[int];
    int          dev_q[$];
    int          next_src = 0;
    int          src;
    bit          req_hs, d_hs, exp_ready, exp_dready, w;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!req_valid && cyc < 600 && $urandom_range(0, 9) < 6) begin
        req_valid = 1; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_be = ($urandom_range(0, 2) == 0) ? 4'hf : 4'($urandom);
      end
      a_ready = $urandom_range(0, 3) != 0;
      rsp_ready = $urandom_range(0, 3) != 0;
      if (!d_valid && dev_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        src = dev_q[$urandom_range(0, dev_q.size() - 1)];
        d_valid = 1; d_source = 8'(src); d_data = $urandom;
        d_error = $urandom_range(0, 9) == 0;
        d_opcode = (inflight[src] ? 3'd0 : 3'd1) ^ 3'($urandom_range(0, 9) == 0);
      end
      #3;
      exp_ready = (exp_a.size() == 0 || a_ready) && !inflight.exists(next_src);
      exp_dready = exp_rsp.size() == 0 || rsp_ready;
      checks++;
      if ({req_ready, d_ready, a_valid, rsp_valid} !==
          {exp_ready, exp_dready, exp_a.size() != 0, exp_rsp.size() != 0}) begin
        errors++;
        $display("FAIL rand_hs cyc %0d: got %b exp %b", cyc, {req_ready, d_ready, a_valid, rsp_valid},
                 {exp_ready, exp_dready, exp_a.size() != 0, exp_rsp.size() != 0});
      end
      if (a_valid && a_ready) begin
        ea = (exp_a.size() > 0) ? exp_a.pop_front() : '0;
        checks++;
        if (a_obs() !== ea) begin errors++; $display("FAIL rand_a cyc %0d: got %h exp %h", cyc, a_obs(), ea); end
        dev_q.push_back(int'(ea[44:37]));
      end
      if (rsp_valid && rsp_ready) begin
        er = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : '0;
        checks++;
        if (rsp_obs() !== er) begin errors++; $display("FAIL rand_rsp cyc %0d: got %h exp %h", cyc, rsp_obs(), er); end
      end
      d_hs = d_valid && d_ready;
      if (d_hs) begin
        src = int'(d_source);
        w = inflight[src];
        exp_rsp.push_back({1'b1, d_error || (d_opcode != (w ? 3'd0 : 3'd1)), d_source, w ? 32'd0 : d_data});
        inflight.delete(src);
        for (int i = 0; i < dev_q.size(); i++)
          if (dev_q[i] == src) begin dev_q.delete(i); break; end
      end
      req_hs = req_valid && req_ready;
      if (req_hs) begin
        exp_a.push_back({1'b1, !req_we ? 3'd4 : (req_be == 4'hf ? 3'd0 : 3'd1), req_we ? req_be : 4'hf,
                         req_addr[31:2], 2'b00, 8'(next_src), 2'd2, 3'd0, req_we ? req_wdata : 32'd0});
        inflight[next_src] = req_we;
        next_src = (next_src + 1) % MO;
      end
      @(negedge clk);
      if (req_hs) req_valid = 0;
      if (d_hs) d_valid = 0;
    end
    checks++;
    if ({busy, err_unexp, err_tmo} !== 3'b000 || inflight.num() != 0 || exp_a.size() != 0 ||
        exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: flags %b, model left %0d inflight %0d a %0d rsp, required all zero",
               {busy, err_unexp, err_tmo}, inflight.num(), exp_a.size(), exp_rsp.size());
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_outstanding();
    test_unexpected();
    test_error_resp();
    test_timeout();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
